pe_tile_param: RTL
==================

// Module: pe_tile_param
// PURPOSE
//  Parametrised successor PE tile: NUM_SIDES x NUM_TRACKS routing tracks of TRACK_WIDTH bits each.
//  Contains two connect boxes, a registered ALU PE with an accumulator, and a switch box.
//  The configuration bus is addressed, supports writes and readback, and has single-cycle read latency.
//  One tile per grid site, chained into the array exactly like the 1-bit tile it replaces.
// PARAMETERS
//  NUM_TRACKS   4   tracks per side
//  TRACK_WIDTH  16  bits per track and ALU datapath width
//  NUM_SIDES    4   fixed at 4 (0=N 1=E 2=S 3=W); any other value is a $error at elaboration
// PORTS
//  clk           in   1       single clock, all state on posedge
//  reset         in   1       asynchronous, active-low (0 = reset)
//  tile_id       in   16      this tile's id
//  config_valid  in   1       config transaction this cycle
//  config_write  in   1       1=write, 0=read (qualified by config_valid)
//  config_addr   in   32      [15:0] tile id, [23:16] module id, [31:24] word index
//  config_data   in   32      write data
//  read_data     out  32      readback data
//  read_valid    out  1       readback strobe
//  in_tracks     in   S*T*W   side s, track t at [((s*T)+t)*W +: W]
//  out_tracks    out  S*T*W   same packing as in_tracks
// BEHAVIOUR
//  Address match: tile = config_addr[15:0]==tile_id. Module ids: CLB=4, CB1=5, CB0=6, SB=7, SBREG=8.
//  Write (valid & write & tile match): target register updates on the next posedge. Unmapped module or index: ignored.
//  Read (valid & !write & tile match): read_valid=1 and read_data=register, both one cycle later.
//   Unmapped module or index returns 0. No tile match: read_valid=0.
//  read_valid is high exactly one cycle per read; back-to-back reads are allowed every cycle.
//  CB0/CB1 word 0, [clog2(2T)-1:0] = sel:
//   sel<T selects in_tracks side 0 (CB0) or side 1 (CB1), track sel.
//   sel>=T selects out_tracks same side, track sel-T.
//  CLB word 0, [3:0] = op: 0 ADD, 1 SUB(a-b), 2 AND, 3 OR, 4 XOR, 5 PASS a, 6 ACC; others behave as PASS a.
//   a=cb0 out, b=cb1 out.
//  pe_output is registered: result of cycle n is visible at n+1.
//   Arithmetic wraps mod 2^W; no carry-out is produced.
//  ACC: acc<=acc+a every cycle; pe_output=acc.
//   Any CLB write clears acc to 0 on the same edge the op is written.
//  SB: 2-bit sel per (side s, track t), 16 sels per word; sel index i=s*T+t lives in word i/16, bits 2*(i%16)+:2.
//   sel k in 0..2 drives out[s][t] from in[(s+1+k)%4][t]; sel 3 drives it from pe_output.
//  Reset (async, mid-operation included): all config registers, acc, pe_output, read_data and read_valid go to 0.
//   out_tracks then equal the combinational function of the zero config (sel 0 everywhere).
//  A write and a read cannot occur in the same cycle: a single transaction per cycle.
// CONFIGURATION
//  PE_SB_OUT_REG_EN defined:
//   SBREG words hold 1 enable bit per (s,t), using the same index layout as the SB selects.
//   Enabled outputs are registered, adding 1 cycle of latency; their registers reset to 0.
//   Disabled outputs are combinational.
//  Undefined: no SBREG storage; all outputs are combinational; SBREG writes are ignored and reads return 0.
// STRUCTURE
//  pe_tile_pkg holds:
//   module-id constants (CLB/CB1/CB0/SB/SBREG);
//   op-code enum;
//   address field offsets;
//   SB_SELS_PER_WORD=16.
//  Sub-module pe_alu_reg: ALU, accumulator, output register and op register.
//   Ports: clk, reset, op_we, op_wdata, a, b, op, pe_output.
//  Connect and switch muxing remain inline generate loops.
// TESTING
//  1. Reset asserted low mid-ACC -> pe_output, acc, read_valid become 0 immediately; all config reads return 0.
//  2. T=4,W=16: CB0 sel=2, CB1 sel=1, op ADD, in[0][2]=0x0003, in[1][1]=0x0005
//     -> pe_output=0x0008 one cycle after inputs settle.
//  3. op SUB with a=0x0000, b=0x0001 -> 0xFFFF.
//     op ACC with a=0x8000 held for 2 cycles -> 0x8000, then 0x0000 (wrap).
//  4. SB word 0 sel for (s=2,t=0)=3, pe_output=0x00AA -> out[2][0]=0x00AA.
//     sel=1 -> out[2][0]=in[0][0].
//  5. Read CB1 sel after writing 5 -> read_valid pulse 1 cycle later, read_data=5.
//     Read with mismatched tile_id -> read_valid stays 0. Read of module 9 -> data 0.
//  6. PE_SB_OUT_REG_EN: enable (s=1,t=3), step in[2][3] 0->0x1234 with sel 0
//     -> out[1][3] changes 1 cycle later; a disabled track changes in the same cycle.

Source files
------------

// File: rtl/pe_tile_pkg.sv
// Shared constants for the parametrised PE tile: config module ids, address
// field offsets, ALU op codes and switch-box select packing helpers.
package pe_tile_pkg;

    localparam logic [7:0] MOD_CLB   = 8'd4;
    localparam logic [7:0] MOD_CB1   = 8'd5;
    localparam logic [7:0] MOD_CB0   = 8'd6;
    localparam logic [7:0] MOD_SB    = 8'd7;
    localparam logic [7:0] MOD_SBREG = 8'd8;

    localparam int ADDR_TILE_LSB = 0;
    localparam int ADDR_MOD_LSB  = 16;
    localparam int ADDR_IDX_LSB  = 24;

    localparam int SB_SELS_PER_WORD = 16;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_PASS = 4'd5,
        OP_ACC  = 4'd6
    } pe_op_e;

    // Select index i = s*T+t lives in config word i/16, slot i%16.
    function automatic logic [7:0] sb_word_of(input int i);
        return 8'(i / SB_SELS_PER_WORD);
    endfunction

    function automatic int sb_slot_of(input int i);
        return i % SB_SELS_PER_WORD;
    endfunction

endpackage

// File: rtl/pe_tile_param_if.sv
// Configuration bus of the PE tile. config_valid qualifies one transaction per
// cycle (write or read, never both); a read answers with a one-cycle read_valid pulse.
interface pe_tile_param_if;
    logic        config_valid;
    logic        config_write;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic [31:0] read_data;
    logic        read_valid;

    modport master (
        output config_valid, config_write, config_addr, config_data,
        input  read_data, read_valid
    );

    modport slave (
        input  config_valid, config_write, config_addr, config_data,
        output read_data, read_valid
    );
endinterface

// File: rtl/pe_alu_reg.sv
// Registered ALU of the PE tile: op register, accumulator and pe_output register.
// Writing the op clears the accumulator on the same edge.
module pe_alu_reg
    import pe_tile_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         op_we,
    input  logic [3:0]   op_wdata,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [3:0]   op,
    output logic [W-1:0] pe_output
);

    logic [3:0]   op_q;
    logic [W-1:0] acc_q, acc_d;
    logic [W-1:0] pe_q, pe_d;

    always_comb begin
        acc_d = acc_q;
        pe_d  = a;
        case (pe_op_e'(op_q))
            OP_ADD: pe_d = a + b;
            OP_SUB: pe_d = a - b;
            OP_AND: pe_d = a & b;
            OP_OR:  pe_d = a | b;
            OP_XOR: pe_d = a ^ b;
            OP_ACC: begin
                acc_d = acc_q + a;
                pe_d  = acc_d;
            end
            default: pe_d = a;
        endcase
        if (op_we) acc_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q  <= '0;
            acc_q <= '0;
            pe_q  <= '0;
        end else begin
            acc_q <= acc_d;
            pe_q  <= pe_d;
            if (op_we) op_q <= op_wdata;
        end
    end

    assign op        = op_q;
    assign pe_output = pe_q;

endmodule

// File: rtl/pe_tile_param.sv
// Parametrised PE tile: two connect boxes, registered ALU PE and a switch box,
// configured over an addressed bus. Optional PE_SB_OUT_REG_EN adds per-output registers.
module pe_tile_param
    import pe_tile_pkg::*;
#(
    parameter int NUM_TRACKS  = 4,
    parameter int TRACK_WIDTH = 16,
    parameter int NUM_SIDES   = 4
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [15:0]                               tile_id,
    pe_tile_param_if.slave                            cfg,
    input  logic [NUM_SIDES*NUM_TRACKS*TRACK_WIDTH-1:0] in_tracks,
    output logic [NUM_SIDES*NUM_TRACKS*TRACK_WIDTH-1:0] out_tracks
);

    localparam int T     = NUM_TRACKS;
    localparam int W     = TRACK_WIDTH;
    localparam int S     = NUM_SIDES;
    localparam int N     = S * T;
    localparam int SEL_W = $clog2(2 * T);

    if (NUM_SIDES != 4) begin : g_bad_sides
        $error("pe_tile_param: NUM_SIDES must be 4");
    end

    logic [W-1:0] in_w  [S][T];
    logic [W-1:0] out_w [S][T];

    logic       tile_hit, wr_en, rd_en;
    logic [7:0] mod_id, word_idx;

    assign tile_hit = (cfg.config_addr[ADDR_TILE_LSB +: 16] == tile_id);
    assign mod_id   = cfg.config_addr[ADDR_MOD_LSB +: 8];
    assign word_idx = cfg.config_addr[ADDR_IDX_LSB +: 8];
    assign wr_en    = cfg.config_valid &  cfg.config_write & tile_hit;
    assign rd_en    = cfg.config_valid & ~cfg.config_write & tile_hit;

    logic [SEL_W-1:0]    cb0_sel_q, cb1_sel_q;
    logic [N-1:0][1:0]   sb_sel_q;
`ifdef PE_SB_OUT_REG_EN
    logic [N-1:0]        sb_en_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cb0_sel_q <= '0;
            cb1_sel_q <= '0;
            sb_sel_q  <= '0;
`ifdef PE_SB_OUT_REG_EN
            sb_en_q   <= '0;
`endif
        end else if (wr_en) begin
            if (mod_id == MOD_CB0 && word_idx == 8'd0) cb0_sel_q <= cfg.config_data[SEL_W-1:0];
            if (mod_id == MOD_CB1 && word_idx == 8'd0) cb1_sel_q <= cfg.config_data[SEL_W-1:0];
            for (int i = 0; i < N; i++) begin
                if (mod_id == MOD_SB && word_idx == sb_word_of(i))
                    sb_sel_q[i] <= cfg.config_data[2*sb_slot_of(i) +: 2];
`ifdef PE_SB_OUT_REG_EN
                if (mod_id == MOD_SBREG && word_idx == sb_word_of(i))
                    sb_en_q[i] <= cfg.config_data[sb_slot_of(i)];
`endif
            end
        end
    end

    logic [3:0]  op;
    logic [31:0] rd_word;
    logic [31:0] read_data_q;
    logic        read_valid_q;

    always_comb begin
        rd_word = '0;
        case (mod_id)
            MOD_CLB: if (word_idx == 8'd0) rd_word[3:0] = op;
            MOD_CB0: if (word_idx == 8'd0) rd_word[SEL_W-1:0] = cb0_sel_q;
            MOD_CB1: if (word_idx == 8'd0) rd_word[SEL_W-1:0] = cb1_sel_q;
            MOD_SB: begin
                for (int i = 0; i < N; i++)
                    if (word_idx == sb_word_of(i)) rd_word[2*sb_slot_of(i) +: 2] = sb_sel_q[i];
            end
`ifdef PE_SB_OUT_REG_EN
            MOD_SBREG: begin
                for (int i = 0; i < N; i++)
                    if (word_idx == sb_word_of(i)) rd_word[sb_slot_of(i)] = sb_en_q[i];
            end
`endif
            default: rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
        end else begin
            read_valid_q <= rd_en;
            if (rd_en) read_data_q <= rd_word;
        end
    end

    assign cfg.read_data  = read_data_q;
    assign cfg.read_valid = read_valid_q;

    // Connect boxes: low selects pick this side's inputs, high selects loop back our own outputs.
    logic [W-1:0] cb0_out, cb1_out, pe_out;

    always_comb begin
        cb0_out = '0;
        cb1_out = '0;
        for (int k = 0; k < T; k++) begin
            if (int'(cb0_sel_q) == k)     cb0_out = in_w[0][k];
            if (int'(cb0_sel_q) == k + T) cb0_out = out_w[0][k];
            if (int'(cb1_sel_q) == k)     cb1_out = in_w[1][k];
            if (int'(cb1_sel_q) == k + T) cb1_out = out_w[1][k];
        end
    end

    pe_alu_reg #(.W(W)) u_alu (
        .clk       (clk),
        .reset     (reset),
        .op_we     (wr_en && mod_id == MOD_CLB && word_idx == 8'd0),
        .op_wdata  (cfg.config_data[3:0]),
        .a         (cb0_out),
        .b         (cb1_out),
        .op        (op),
        .pe_output (pe_out)
    );

    for (genvar s = 0; s < S; s++) begin : g_side
        for (genvar t = 0; t < T; t++) begin : g_track
            localparam int I = s * T + t;
            logic [W-1:0] sb_d;

            assign in_w[s][t] = in_tracks[I*W +: W];

            always_comb begin
                case (sb_sel_q[I])
                    2'd0:    sb_d = in_w[(s+1)%S][t];
                    2'd1:    sb_d = in_w[(s+2)%S][t];
                    2'd2:    sb_d = in_w[(s+3)%S][t];
                    default: sb_d = pe_out;
                endcase
            end

`ifdef PE_SB_OUT_REG_EN
            logic [W-1:0] sb_q;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) sb_q <= '0;
                else        sb_q <= sb_d;
            end
            assign out_w[s][t] = sb_en_q[I] ? sb_q : sb_d;
`else
            assign out_w[s][t] = sb_d;
`endif
            assign out_tracks[I*W +: W] = out_w[s][t];
        end
    end

endmodule
